multi_key_debouncer: RTL and testbench
======================================

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent key inputs (1..32).
REQ-002 SHALL have parameter CLK_FREQ_MHZ, default 5, clock frequency in MHz.
REQ-003 SHALL have parameter GLITCH_TIME_NS, default 2000, minimum stable time accepted as a real transition.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; 1 means a pressed key drives key_i low.
REQ-005 SHALL have parameter REPEAT_CYCLES, default 1000, auto-repeat period in clocks (used only with REQ-025).
REQ-006 SHALL have port clk_i  input  1  single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port key_i  input  CHANNELS  raw asynchronous key levels.
REQ-009 SHALL have port key_state_o  output  CHANNELS  debounced level, 1 = pressed, polarity-normalised.
REQ-010 SHALL have port key_pressed_stb_o  output  CHANNELS  one-cycle pulse on accepted press.
REQ-011 SHALL have port key_released_stb_o  output  CHANNELS  one-cycle pulse on accepted release.
REQ-012 SHALL have port key_repeat_stb_o  output  CHANNELS  one-cycle auto-repeat pulse.
REQ-013 SHALL have port any_pressed_stb_o  output  1  OR of all key_pressed_stb_o bits, registered, same cycle.

Function
REQ-014 SHALL derive STABLE_CYCLES = ceil(GLITCH_TIME_NS*CLK_FREQ_MHZ/1000), clamped to minimum 1, computed at elaboration in integer arithmetic.
REQ-015 SHALL size each channel counter to $clog2(STABLE_CYCLES+1) bits; the counter never wraps.
REQ-016 SHALL pass each key_i bit through a 2-flop synchroniser, then XOR with ACTIVE_LOW to give normalised level s.
REQ-017 SHALL, per channel, clear the counter on any edge where s equals key_state_o.
REQ-018 SHALL, per channel, increment the counter on each edge where s differs from key_state_o and counter < STABLE_CYCLES-1.
REQ-019 SHALL, on an edge where s differs from key_state_o and counter == STABLE_CYCLES-1, toggle key_state_o and clear the counter.
REQ-020 SHALL assert key_pressed_stb_o (0->1 toggle) or key_released_stb_o (1->0 toggle) for exactly the one cycle following the toggling edge, aligned with the new key_state_o.
REQ-021 SHALL give latency key_i step -> key_state_o change of exactly STABLE_CYCLES+2 clock edges for a clean step.
REQ-022 SHALL discard any pulse on s shorter than STABLE_CYCLES consecutive cycles with no output effect; a single agreeing cycle restarts the count.
REQ-023 SHALL process channels fully independently; simultaneous toggles on several channels each produce their own strobe in the same cycle.
REQ-024 SHALL never assert pressed and released strobes together on one channel.

Configuration
REQ-025 SHALL, with macro MULTI_KEY_DEBOUNCER_REPEAT_EN defined, per channel run a repeat counter while key_state_o is 1, pulse key_repeat_stb_o for one cycle every REPEAT_CYCLES clocks (first pulse REPEAT_CYCLES clocks after the press strobe), and clear it on release.
REQ-026 SHALL, without MULTI_KEY_DEBOUNCER_REPEAT_EN, tie key_repeat_stb_o to 0 and instantiate no repeat counters; REPEAT_CYCLES is then ignored.

Reset
REQ-027 SHALL, while rst_ni is low, force synchroniser flops to the released level, counters to 0, and all outputs to 0, independent of clk_i.
REQ-028 SHALL, on reset mid-transition, abort the pending count with no strobe; a key held pressed through reset release yields a press strobe STABLE_CYCLES+2 edges after the first post-reset edge.

Verification
REQ-029 SHALL verify: defaults (STABLE_CYCLES=10), key_i[0] 0->1 held -> key_state_o[0]=1 and key_pressed_stb_o[0] one cycle at edge 12; any_pressed_stb_o same cycle.
REQ-030 SHALL verify: 9-cycle high glitch on key_i[1] -> no output change; then glitches of 9,9 with 1-cycle low gaps -> still no change.
REQ-031 SHALL verify: ACTIVE_LOW=1, key_i[2] 1->0 held 12 cycles then 0->1 held -> press strobe then release strobe, key_state_o[2] 1 then 0.
REQ-032 SHALL verify: all 4 keys pressed same cycle -> key_pressed_stb_o=4'b1111 in one cycle, any_pressed_stb_o single pulse.
REQ-033 SHALL verify: rst_ni low at counter=5 with key held -> no strobe; after release press strobe 12 edges later.
REQ-034 SHALL verify: with MULTI_KEY_DEBOUNCER_REPEAT_EN, REPEAT_CYCLES=50, key held 200 cycles after press -> key_repeat_stb_o pulses at +50,+100,+150; none after release.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stability counter, press/release strobes.
// Optional auto-repeat strobes are built only when MULTI_KEY_DEBOUNCER_REPEAT_EN is defined.
module multi_key_debouncer #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_MHZ   = 5,
  parameter int GLITCH_TIME_NS = 2000,
  parameter int ACTIVE_LOW     = 0,
  parameter int REPEAT_CYCLES  = 1000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o,
  output logic [CHANNELS-1:0] key_repeat_stb_o,
  output logic                any_pressed_stb_o
);

  localparam int STABLE_RAW    = (GLITCH_TIME_NS * CLK_FREQ_MHZ + 999) / 1000;
  localparam int STABLE_CYCLES = (STABLE_RAW < 1) ? 1 : STABLE_RAW;
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // Raw idle level of the pins; also the normalisation mask.
  localparam logic [CHANNELS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  if (CHANNELS < 1 || CHANNELS > 32 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("multi_key_debouncer: CHANNELS must be 1..32 and REPEAT_CYCLES >= 1");
  end

  logic [CHANNELS-1:0] sync_p0, sync_p1;
  logic [CHANNELS-1:0] lvl_s;
  logic [CHANNELS-1:0] state_q, press_q, release_q;
  logic                any_q;
  logic [CHANNELS-1:0] toggle;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= POL_MASK;
      sync_p1 <= POL_MASK;
    end else begin
      sync_p0 <= key_i;
      sync_p1 <= sync_p0;
    end
  end

  assign lvl_s = sync_p1 ^ POL_MASK;

  always_comb begin
    toggle = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_d[ch] = '0;
      if (lvl_s[ch] != state_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) toggle[ch] = 1'b1;
        else                       cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Stage p2: debounced state and edge strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= cnt_d[ch];
      state_q   <= state_q ^ toggle;
      press_q   <= toggle & ~state_q;
      release_q <= toggle & state_q;
      any_q     <= |(toggle & ~state_q);
    end
  end

  assign key_state_o        = state_q;
  assign key_pressed_stb_o  = press_q;
  assign key_released_stb_o = release_q;
  assign any_pressed_stb_o  = any_q;

`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0]    rep_cnt_q [CHANNELS];
  logic [CHANNELS-1:0] rep_q;

  // Counts only while held and stable, so the first pulse lands REPEAT_CYCLES after the press strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ch = 0; ch < CHANNELS; ch++) rep_cnt_q[ch] <= '0;
      rep_q <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        rep_q[ch] <= 1'b0;
        if (state_q[ch] && !toggle[ch]) begin
          if (rep_cnt_q[ch] == REP_LAST) begin
            rep_cnt_q[ch] <= '0;
            rep_q[ch]     <= 1'b1;
          end else begin
            rep_cnt_q[ch] <= rep_cnt_q[ch] + REP_W'(1);
          end
        end else begin
          rep_cnt_q[ch] <= '0;
        end
      end
    end
  end

  assign key_repeat_stb_o = rep_q;
`else
  assign key_repeat_stb_o = '0;
`endif

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Scoreboard bench for multi_key_debouncer: expected strobe events are queued by the stimulus
// and checked by per-DUT monitors (active-high instance and active-low instance).
`timescale 1ns/1ps
module tb_multi_key_debouncer;

  typedef struct {
    int       cyc;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] st;
    logic       any;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] key_a, key_b;
  logic [3:0] a_st, a_prs, a_rel, a_rpt;
  logic [3:0] b_st, b_prs, b_rel, b_rpt;
  logic       a_any, b_any;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t qa[$];
  ev_t qb[$];
  ev_t ea, eb;

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_key_debouncer #(.CHANNELS(4), .REPEAT_CYCLES(50)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_a),
    .key_state_o(a_st), .key_pressed_stb_o(a_prs), .key_released_stb_o(a_rel),
    .key_repeat_stb_o(a_rpt), .any_pressed_stb_o(a_any)
  );

  multi_key_debouncer #(.CHANNELS(4), .ACTIVE_LOW(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_b),
    .key_state_o(b_st), .key_pressed_stb_o(b_prs), .key_released_stb_o(b_rel),
    .key_repeat_stb_o(b_rpt), .any_pressed_stb_o(b_any)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mk(output ev_t e, input int c, input logic [3:0] p, input logic [3:0] r,
                    input logic [3:0] rp, input logic [3:0] st, input logic any);
    e.cyc = c; e.prs = p; e.rel = r; e.rpt = rp; e.st = st; e.any = any;
  endtask

  task automatic push_a(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] rp, input logic [3:0] st, input logic any);
    ev_t e;
    mk(e, c, p, r, rp, st, any);
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] rp, input logic [3:0] st, input logic any);
    ev_t e;
    mk(e, c, p, r, rp, st, any);
    qb.push_back(e);
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_idle_a(input string nm, input logic [3:0] st);
    cmp({nm, "_a_state"}, a_st, st);
    cmp({nm, "_a_strobes"}, {a_prs, a_rel, a_rpt, 3'b0, a_any}, 16'h0);
  endtask

  task automatic chk_idle_b(input string nm, input logic [3:0] st);
    cmp({nm, "_b_state"}, b_st, st);
    cmp({nm, "_b_strobes"}, {b_prs, b_rel, b_rpt, 3'b0, b_any}, 16'h0);
  endtask

  always @(negedge clk) begin
    if ((a_prs | a_rel | a_rpt) != 4'h0 || a_any) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected actual prs=%h rel=%h rpt=%h any=%b required none (cycle %0d)",
                 a_prs, a_rel, a_rpt, a_any, cyc);
      end else begin
        ea = qa.pop_front();
        cmp("a_cycle", cyc, ea.cyc);
        cmp("a_pressed", a_prs, ea.prs);
        cmp("a_released", a_rel, ea.rel);
        cmp("a_repeat", a_rpt, ea.rpt);
        cmp("a_any", a_any, ea.any);
        cmp("a_state", a_st, ea.st);
      end
    end
  end

  always @(negedge clk) begin
    if ((b_prs | b_rel | b_rpt) != 4'h0 || b_any) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected actual prs=%h rel=%h rpt=%h any=%b required none (cycle %0d)",
                 b_prs, b_rel, b_rpt, b_any, cyc);
      end else begin
        eb = qb.pop_front();
        cmp("b_cycle", cyc, eb.cyc);
        cmp("b_pressed", b_prs, eb.prs);
        cmp("b_released", b_rel, eb.rel);
        cmp("b_repeat", b_rpt, eb.rpt);
        cmp("b_any", b_any, eb.any);
        cmp("b_state", b_st, eb.st);
      end
    end
  end

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0;
    key_a = 4'h0;
    key_b = 4'hF;
    go(3);
    chk_idle_a("reset", 4'h0);
    chk_idle_b("reset", 4'h0);
    // Keys pressed while reset is held must not reach the outputs.
    key_a = 4'hF;
    key_b = 4'h0;
    go(14);
    chk_idle_a("reset_held", 4'h0);
    chk_idle_b("reset_held", 4'h0);
    key_a = 4'h0;
    key_b = 4'hF;
    go(2);
    rst_n = 1'b1;
    go(20);
    chk_idle_a("post_reset", 4'h0);
    chk_idle_b("post_reset", 4'h0);

    // Clean press on key 0, 12-edge latency, then held (auto-repeat when built in).
    t0 = cyc;
    key_a[0] = 1'b1;
    push_a(t0 + 12, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
    push_a(t0 + 12 + 50,  4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    push_a(t0 + 12 + 100, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
    push_a(t0 + 12 + 150, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
`endif
    go(11);
    cmp("latency_pre_state", a_st, 4'h0);
    go(1);
    cmp("latency_state", a_st, 4'h1);
    go(170);
    t1 = cyc;
    key_a[0] = 1'b0;
    push_a(t1 + 12, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
    go(80);

    // Glitches on key 1 one cycle shorter than the stable time.
    key_a[1] = 1'b1; go(9); key_a[1] = 1'b0;
    go(20);
    chk_idle_a("glitch9", 4'h0);
    key_a[1] = 1'b1; go(9); key_a[1] = 1'b0; go(1);
    key_a[1] = 1'b1; go(9); key_a[1] = 1'b0; go(1);
    go(20);
    chk_idle_a("glitch9x2", 4'h0);

    // A pulse of exactly the stable time is accepted.
    t0 = cyc;
    key_a[2] = 1'b1;
    push_a(t0 + 12, 4'h4, 4'h0, 4'h0, 4'h4, 1'b1);
    go(10);
    key_a[2] = 1'b0;
    push_a(t0 + 22, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
    go(25);

    // All four keys at once: one combined strobe, one any-pulse.
    t0 = cyc;
    key_a = 4'hF;
    push_a(t0 + 12, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1);
    go(20);
    t1 = cyc;
    key_a = 4'h0;
    push_a(t1 + 12, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
    go(20);

    // Reset while key 3's counter sits at 5, key held through reset release.
    t0 = cyc;
    key_a[3] = 1'b1;
    go(7);
    rst_n = 1'b0;
    go(1);
    chk_idle_a("mid_reset", 4'h0);
    go(2);
    t2 = cyc;
    rst_n = 1'b1;
    push_a(t2 + 12, 4'h8, 4'h0, 4'h0, 4'h8, 1'b1);
    go(20);
    t1 = cyc;
    key_a[3] = 1'b0;
    push_a(t1 + 12, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0);
    go(20);

    // Active-low instance: key 2 pulled low for 12 cycles, then released.
    t0 = cyc;
    key_b[2] = 1'b0;
    push_b(t0 + 12, 4'h4, 4'h0, 4'h0, 4'h4, 1'b1);
    go(12);
    t1 = cyc;
    cmp("b_held_state", b_st, 4'h4);
    key_b[2] = 1'b1;
    push_b(t1 + 12, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
    go(20);
    cmp("b_final_state", b_st, 4'h0);

    go(30);
    cmp("a_events_left", qa.size(), 0);
    cmp("b_events_left", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
